adc_capture_buffer: RTL and testbench
=====================================

ADC_CAPTURE_BUFFER -- requirements
Module: adc_capture_buffer

Interface
REQ-001 Parameter AW, default 10, buffer address width; depth D = 2^AW samples.
REQ-002 Parameter DW, default 14, ADC sample width.
REQ-003 clk  in  1  sample clock, the ADC clock (CLK_65 at top level); all logic on rising edge.
REQ-004 areset  in  1  asynchronous, active-high reset.
REQ-005 adc_d  in  DW  raw offset-binary ADC word (ADC_DA or ADC_DB).
REQ-006 adc_otr  in  1  ADC out-of-range flag, aligned with adc_d.
REQ-007 arm  in  1  single-cycle pulse; starts a new capture.
REQ-008 force_trig  in  1  forces a trigger while in WAIT_TRIG.
REQ-009 trig_level  in  DW  two's-complement trigger threshold.
REQ-010 trig_rise  in  1  1 = rising-edge trigger, 0 = falling-edge trigger.
REQ-011 pretrig  in  AW  number of samples kept before the trigger.
REQ-012 rd_en  in  1  readout request, one sample per asserted cycle.
REQ-013 rd_data  out  DW  two's-complement sample read from the buffer.
REQ-014 rd_valid  out  1  rd_data is valid this cycle.
REQ-015 rd_last  out  1  asserted with rd_valid on the final (D-th) sample.
REQ-016 state  out  3  current state encoding: IDLE=0, PRE=1, WAIT_TRIG=2, POST=3, DONE=4.
REQ-017 ovr_seen  out  1  sticky flag: adc_otr was high during the capture.

Function
REQ-018 The input stage SHALL register adc_d and adc_otr each cycle and convert the sample as s = {~adc_d[DW-1], adc_d[DW-2:0]}, which gives two's-complement with 1 cycle of latency.
REQ-019 A prev register SHALL hold the previous s; trigger crossing on rising edge = (prev < trig_level) and (s >= trig_level), compared as signed; falling edge is the mirror condition.
REQ-020 Buffer: D x DW single-clock RAM, circular write pointer wp of AW bits, wraps D-1 -> 0.
REQ-021 IDLE: no writes; arm -> PRE, clearing wp, the sample count, ovr_seen and the readout counter.
REQ-022 PRE: write s every cycle; after P = min(pretrig, D-1) writes -> WAIT_TRIG; P = 0 goes directly to WAIT_TRIG.
REQ-023 WAIT_TRIG: write s every cycle (wp keeps wrapping); on a crossing or force_trig, latch taddr = wp of the triggering sample, write that sample, -> POST.
REQ-024 POST: write until D-P-1 samples after the trigger sample are written -> DONE; the buffer then holds P pre-trigger samples, the trigger sample, and D-P-1 post-trigger samples.
REQ-025 DONE: no writes; readout start address = (taddr - P) mod D.
REQ-026 Readout: in DONE, each rd_en cycle reads the next address; rd_data and rd_valid appear exactly 1 cycle later; rd_en in other states is ignored and produces no rd_valid.
REQ-027 On the D-th read: rd_last = 1 with rd_valid; the next cycle -> IDLE.
REQ-028 arm in any non-IDLE state SHALL restart the capture (same actions as REQ-021, -> PRE), and any pending rd_valid SHALL be suppressed.
REQ-029 arm and force_trig in the same cycle: arm wins.
REQ-030 ovr_seen SHALL be set by any adc_otr sample that is written during PRE, WAIT_TRIG or POST, and SHALL hold until the next arm or reset.
REQ-031 pretrig and trig_level SHALL be sampled at arm and held constant for the rest of that capture.

Reset
REQ-032 On areset: state=IDLE, wp=0, prev=0, rd_data=0, rd_valid=0, rd_last=0, ovr_seen=0; RAM contents undefined.
REQ-033 areset asserted mid-capture or mid-readout SHALL abort immediately; no rd_valid is produced until a new capture completes.

Verification
V1 AW=4, pretrig=4, ramp input s=-8..+7 repeating, level=0, trig_rise=1 -> readout of 16 samples = -4,-3,-2,-1,0,1..11 wrapped per ramp; the 5th sample = 0; rd_last on the 16th.
V2 pretrig=0, force_trig one cycle after arm -> first read = the sample present at the force, DONE reached 15 cycles later (AW=4).
V3 Trigger arrives while wp is near wrap (taddr=2, P=4) -> start address 14; readout addresses 14,15,0,...,13.
V4 adc_otr pulsed once in POST -> ovr_seen=1 in DONE; a new arm -> ovr_seen=0.
V5 arm pulsed mid-readout (after 5 reads) -> rd_valid drops the next cycle, state=PRE, and the following capture is correct.
V6 areset in POST, then rd_en held high -> no rd_valid, state=IDLE, all outputs at reset values.

Source files
------------

// File: rtl/adc_capture_buffer.sv
// ADC capture buffer: registers and converts offset-binary ADC samples to
// two's complement, records them into a circular RAM around a level-crossing
// (or forced) trigger with a programmable pre-trigger depth, then plays the
// whole buffer back oldest-first on request.
module adc_capture_buffer #(
  parameter int AW = 10,
  parameter int DW = 14
) (
  input  logic          clk,
  input  logic          areset,
  input  logic [DW-1:0] adc_d,
  input  logic          adc_otr,
  input  logic          arm,
  input  logic          force_trig,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_rise,
  input  logic [AW-1:0] pretrig,
  input  logic          rd_en,
  output logic [DW-1:0] rd_data,
  output logic          rd_valid,
  output logic          rd_last,
  output logic [2:0]    state,
  output logic          ovr_seen
);

  localparam int D = 1 << AW;
  localparam logic [AW-1:0] ADDR_ZERO = {AW{1'b0}};
  localparam logic [AW-1:0] ADDR_ONE  = {{(AW-1){1'b0}}, 1'b1};
  localparam logic [AW-1:0] ADDR_MAX  = {AW{1'b1}};
  localparam logic [DW-1:0] DATA_ZERO = {DW{1'b0}};

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_PRE  = 3'd1,
    ST_WAIT = 3'd2,
    ST_POST = 3'd3,
    ST_DONE = 3'd4
  } state_t;

  // Offset binary to two's complement: flip the MSB.
  function automatic logic [DW-1:0] to_twos(input logic [DW-1:0] raw);
    return {~raw[DW-1], raw[DW-2:0]};
  endfunction

  state_t          state_r, state_nxt_s;
  logic [DW-1:0]   s_r, prev_r, level_r;
  logic            otr_r, ovr_r;
  logic [AW-1:0]   wp_r, cnt_r, pre_r, taddr_r, rd_cnt_r;
  logic [DW-1:0]   mem_r [D];
  logic [DW-1:0]   rd_data_r;
  logic            rd_valid_r, rd_last_r;
  logic            wr_en_s, trig_s, start_s, rd_fire_s, cross_s;
  logic [AW-1:0]   pre_last_s, post_last_s, rd_addr_s;

  // Input stage: register the ADC word and flag, keep the previous sample.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      s_r    <= DATA_ZERO;
      prev_r <= DATA_ZERO;
      otr_r  <= 1'b0;
    end else begin
      s_r    <= to_twos(adc_d);
      prev_r <= s_r;
      otr_r  <= adc_otr;
    end
  end

  // Next-state, write enable, trigger and readout decisions.
  always_comb begin
    state_nxt_s = state_r;
    wr_en_s     = 1'b0;
    trig_s      = 1'b0;
    start_s     = 1'b0;
    rd_fire_s   = 1'b0;
    pre_last_s  = pre_r - ADDR_ONE;
    // D-P-1 post samples; ~P equals D-1-P in AW bits.
    post_last_s = ~pre_r - ADDR_ONE;
    // Oldest sample sits P slots before the trigger sample.
    rd_addr_s   = taddr_r - pre_r + rd_cnt_r;
    if (trig_rise) begin
      cross_s = ($signed(prev_r) < $signed(level_r)) && ($signed(s_r) >= $signed(level_r));
    end else begin
      cross_s = ($signed(prev_r) > $signed(level_r)) && ($signed(s_r) <= $signed(level_r));
    end
    if (arm) begin
      // arm restarts from any state and outranks force_trig and reads.
      start_s = 1'b1;
      if (pretrig == ADDR_ZERO) begin
        state_nxt_s = ST_WAIT;
      end else begin
        state_nxt_s = ST_PRE;
      end
    end else begin
      case (state_r)
        ST_IDLE: begin
          state_nxt_s = ST_IDLE;
        end
        ST_PRE: begin
          wr_en_s = 1'b1;
          if (cnt_r == pre_last_s) begin
            state_nxt_s = ST_WAIT;
          end else begin
            state_nxt_s = ST_PRE;
          end
        end
        ST_WAIT: begin
          wr_en_s = 1'b1;
          if (cross_s || force_trig) begin
            trig_s = 1'b1;
            // With P = D-1 there are no post-trigger samples to take.
            if (pre_r == ADDR_MAX) begin
              state_nxt_s = ST_DONE;
            end else begin
              state_nxt_s = ST_POST;
            end
          end else begin
            state_nxt_s = ST_WAIT;
          end
        end
        ST_POST: begin
          wr_en_s = 1'b1;
          if (cnt_r == post_last_s) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = ST_POST;
          end
        end
        ST_DONE: begin
          if (rd_en) begin
            rd_fire_s = 1'b1;
            if (rd_cnt_r == ADDR_MAX) begin
              state_nxt_s = ST_IDLE;
            end else begin
              state_nxt_s = ST_DONE;
            end
          end else begin
            state_nxt_s = ST_DONE;
          end
        end
        default: begin
          state_nxt_s = ST_IDLE;
        end
      endcase
    end
  end

  // State register.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Capture bookkeeping: pointers, counters, latched settings, overrange flag.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      wp_r     <= ADDR_ZERO;
      cnt_r    <= ADDR_ZERO;
      pre_r    <= ADDR_ZERO;
      taddr_r  <= ADDR_ZERO;
      rd_cnt_r <= ADDR_ZERO;
      level_r  <= DATA_ZERO;
      ovr_r    <= 1'b0;
    end else if (start_s) begin
      // pretrig is AW bits wide, so it never exceeds D-1.
      wp_r     <= ADDR_ZERO;
      cnt_r    <= ADDR_ZERO;
      rd_cnt_r <= ADDR_ZERO;
      ovr_r    <= 1'b0;
      pre_r    <= pretrig;
      level_r  <= trig_level;
    end else begin
      if (wr_en_s) begin
        wp_r <= wp_r + ADDR_ONE;
        if (otr_r) begin
          ovr_r <= 1'b1;
        end
      end
      if (trig_s) begin
        taddr_r <= wp_r;
        cnt_r   <= ADDR_ZERO;
      end else if (wr_en_s) begin
        cnt_r <= cnt_r + ADDR_ONE;
      end
      if (rd_fire_s) begin
        rd_cnt_r <= rd_cnt_r + ADDR_ONE;
      end
    end
  end

  // Sample RAM write port.
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_r[wp_r] <= s_r;
    end
  end

  // Readout port: one registered sample per accepted request.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      rd_data_r  <= DATA_ZERO;
      rd_valid_r <= 1'b0;
      rd_last_r  <= 1'b0;
    end else begin
      rd_valid_r <= rd_fire_s;
      rd_last_r  <= rd_fire_s && (rd_cnt_r == ADDR_MAX);
      if (rd_fire_s) begin
        rd_data_r <= mem_r[rd_addr_s];
      end
    end
  end

  assign rd_data  = rd_data_r;
  assign rd_valid = rd_valid_r;
  assign rd_last  = rd_last_r;
  assign state    = state_r;
  assign ovr_seen = ovr_r;

endmodule

// File: tb/tb_adc_capture_buffer.sv
// Bench for adc_capture_buffer (AW=4): table-driven ramp captures, directed
// corner sequences and randomized captures checked against a window model of
// the recorded sample stream.
module tb_adc_capture_buffer;
  localparam int AW = 4;
  localparam int DW = 14;
  localparam int D  = 16;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic [DW-1:0] adc_d = '0;
  logic          adc_otr = 1'b0;
  logic          arm = 1'b0;
  logic          force_trig = 1'b0;
  logic [DW-1:0] trig_level = '0;
  logic          trig_rise = 1'b1;
  logic [AW-1:0] pretrig = '0;
  logic          rd_en = 1'b0;
  logic [DW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_last;
  logic [2:0]    state;
  logic          ovr_seen;

  adc_capture_buffer #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .areset(areset), .adc_d(adc_d), .adc_otr(adc_otr), .arm(arm),
    .force_trig(force_trig), .trig_level(trig_level), .trig_rise(trig_rise),
    .pretrig(pretrig), .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
    .rd_last(rd_last), .state(state), .ovr_seen(ovr_seen)
  );

  always #5 clk = ~clk;

  typedef struct {
    int pre;
    int lvl;
    bit rise;
    int first;
  } vec_t;

  int vectors = 0;
  int miscompares = 0;
  int hist_s [16384];
  bit hist_o [16384];
  bit hist_f [16384];
  int ec = 0;
  int cur_s = 0;
  bit cur_o = 1'b0;
  int ramp = -8;
  int dmode = 0;
  int a_edge = 0;
  int m_pre = 0;
  int m_lvl = 0;
  bit m_rise = 1'b1;
  int done_edge = -1;
  int exp_rd [D];
  vec_t tbl [5];

  initial begin
    #500000;
    $display("FAIL watchdog: got no end of test, expected finish before time limit");
    $fatal(1);
  end

  task automatic check(string name, int act, int req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  function automatic int wrap16(int x);
    return ((x + 8) % 16 + 16) % 16 - 8;
  endfunction

  task automatic drive_sample();
    logic [DW-1:0] v;
    if (dmode == 0) begin
      cur_s = ramp;
      ramp  = (ramp == 7) ? -8 : ramp + 1;
      cur_o = 1'b0;
    end else begin
      cur_s = int'($urandom_range(20)) - 10;
      cur_o = ($urandom_range(39) == 0);
    end
    v = cur_s[DW-1:0];
    adc_d   = {~v[DW-1], v[DW-2:0]};
    adc_otr = cur_o;
  endtask

  // One clock: drive a fresh sample, record what the edge sees, settle.
  task automatic step();
    drive_sample();
    @(posedge clk);
    hist_s[ec] = cur_s;
    hist_o[ec] = cur_o;
    hist_f[ec] = force_trig;
    ec++;
    #1;
  endtask

  task automatic arm_step(int pre, int lvl, bit rise);
    pretrig    = pre[AW-1:0];
    trig_level = lvl[DW-1:0];
    trig_rise  = rise;
    arm        = 1'b1;
    m_pre  = pre;
    m_lvl  = lvl;
    m_rise = rise;
    step();
    a_edge = ec - 1;
    arm = 1'b0;
    check("ovr_clear_on_arm", int'(ovr_seen), 0);
    check("rd_valid_after_arm", int'(rd_valid), 0);
    check("state_after_arm", int'(state), (pre == 0) ? 2 : 1);
  endtask

  // Run until DONE, then predict trigger edge, DONE edge, buffer and ovr.
  task automatic wait_done(bit force_first, int fpct);
    int n = 0;
    int t = -1;
    int pv;
    int sv;
    bit hit;
    bit o = 1'b0;
    done_edge = -1;
    force_trig = force_first;
    while (done_edge < 0 && n < 400) begin
      step();
      n++;
      force_trig = ($urandom_range(99) < fpct);
      pretrig    = AW'($urandom_range(15));
      trig_level = DW'($urandom);
      if (state == 3'd4) done_edge = ec - 1;
    end
    force_trig = 1'b0;
    check("done_reached", int'(done_edge >= 0), 1);
    if (done_edge < 0) return;
    for (int m = a_edge + m_pre + 1; m < ec && t < 0; m++) begin
      pv  = hist_s[m-2];
      sv  = hist_s[m-1];
      hit = m_rise ? (pv < m_lvl && sv >= m_lvl) : (pv > m_lvl && sv <= m_lvl);
      if (hit || hist_f[m]) t = m;
    end
    check("trigger_found", int'(t >= 0), 1);
    if (t < 0) return;
    check("done_edge", done_edge, t + D - m_pre - 1);
    for (int k = 0; k < D; k++) exp_rd[k] = hist_s[t - 1 - m_pre + k];
    for (int j = a_edge; j <= t + D - m_pre - 2; j++) o = o | hist_o[j];
    check("ovr_seen", int'(ovr_seen), int'(o));
  endtask

  task automatic readout(int nreads, bit chk_tbl, int first);
    int k = 0;
    int n = 0;
    while (k < nreads && n < 200) begin
      rd_en = ($urandom_range(3) != 0);
      step();
      n++;
      if (rd_en) begin
        check("rd_valid", int'(rd_valid), 1);
        check("rd_data", int'($signed(rd_data)), exp_rd[k]);
        check("rd_last", int'(rd_last), (k == D - 1) ? 1 : 0);
        if (chk_tbl) check("rd_data_tbl", int'($signed(rd_data)), wrap16(first + k));
        k++;
      end else begin
        check("rd_valid_idle", int'(rd_valid), 0);
      end
    end
    rd_en = 1'b0;
    check("reads_done", k, nreads);
    if (nreads == D) check("idle_after_readout", int'(state), 0);
  endtask

  initial begin
    int n;
    tbl[0] = '{pre: 4,  lvl: 0,  rise: 1'b1, first: -4};
    tbl[1] = '{pre: 0,  lvl: 3,  rise: 1'b1, first: 3};
    tbl[2] = '{pre: 10, lvl: 5,  rise: 1'b1, first: -5};
    tbl[3] = '{pre: 2,  lvl: -3, rise: 1'b0, first: 6};
    tbl[4] = '{pre: 15, lvl: 2,  rise: 1'b1, first: 3};

    // Reset values
    areset = 1'b1;
    repeat (3) step();
    check("rst_state", int'(state), 0);
    check("rst_rd_valid", int'(rd_valid), 0);
    check("rst_rd_last", int'(rd_last), 0);
    check("rst_rd_data", int'(rd_data), 0);
    check("rst_ovr", int'(ovr_seen), 0);
    areset = 1'b0;
    repeat (3) step();

    // Ramp captures from the table
    dmode = 0;
    for (int i = 0; i < 5; i++) begin
      repeat (2) step();
      arm_step(tbl[i].pre, tbl[i].lvl, tbl[i].rise);
      wait_done(1'b0, 0);
      readout(D, 1'b1, tbl[i].first);
    end

    // Forced trigger right after arm with no pre-trigger samples
    dmode = 1;
    repeat (2) step();
    arm_step(0, 8191, 1'b1);
    wait_done(1'b1, 0);
    check("force_done_latency", done_edge - a_edge, 16);
    readout(D, 1'b0, 0);

    // Randomized captures
    for (int i = 0; i < 20; i++) begin
      repeat (2) step();
      arm_step(int'($urandom_range(15)), int'($urandom_range(16)) - 8, 1'(($urandom_range(1))));
      wait_done(1'b0, int'($urandom_range(3)));
      readout(D, 1'b0, 0);
    end

    // arm in the middle of a readout, with a read request in the same cycle
    repeat (2) step();
    arm_step(6, 0, 1'b1);
    wait_done(1'b0, 2);
    readout(5, 1'b0, 0);
    rd_en = 1'b1;
    arm_step(3, 2, 1'b1);
    rd_en = 1'b0;
    wait_done(1'b0, 2);
    readout(D, 1'b0, 0);

    // areset during POST, then read requests held high
    repeat (2) step();
    arm_step(5, 0, 1'b1);
    force_trig = 1'b1;
    n = 0;
    while (state != 3'd3 && n < 100) begin
      step();
      n++;
    end
    force_trig = 1'b0;
    check("reach_post", int'(state == 3'd3), 1);
    areset = 1'b1;
    #1;
    check("abort_state", int'(state), 0);
    check("abort_ovr", int'(ovr_seen), 0);
    step();
    areset = 1'b0;
    rd_en = 1'b1;
    for (int i = 0; i < 20; i++) begin
      step();
      check("post_abort_rd_valid", int'(rd_valid), 0);
      check("post_abort_state", int'(state), 0);
    end
    rd_en = 1'b0;
    check("post_abort_rd_data", int'(rd_data), 0);
    check("post_abort_rd_last", int'(rd_last), 0);
    check("post_abort_ovr", int'(ovr_seen), 0);

    // Recovery capture after the abort
    repeat (3) step();
    arm_step(7, -2, 1'b0);
    wait_done(1'b0, 2);
    readout(D, 1'b0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
